// File: rtl/sha256_msg_padder_pkg.sv
// Shared types, constants and helpers for the SHA-256 message padder.
// Optional build macro SHA256_PAD_BSWAP_EN byte-reverses every fetched message word.
package sha256_pkg;

  localparam int          WORDS_PER_BLOCK = 16;
  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRESENT
  } pad_state_e;

  // Blocks needed for 'words' message words plus the pad word and the 64-bit length.
  function automatic int num_blocks(input int words);
    return (words + 2) / WORDS_PER_BLOCK + 1;
  endfunction

  function automatic logic [31:0] fmt_mem_word(input logic [31:0] w);
`ifdef SHA256_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/sha256_msg_padder_pad_sel.sv
// Combinational slot-value selector: message word, pad word, length words or zero.
module sha256_pad_sel
  import sha256_pkg::*;
(
  input  logic [15:0] i_g,
  input  logic [11:0] i_blk,
  input  logic [3:0]  i_slot,
  input  logic [11:0] i_nb,
  input  logic [63:0] i_msg_bits,
  input  logic [31:0] i_mem_word,
  output logic [31:0] o_value,
  output logic        o_is_mem
);

  logic [15:0] w_num_words;
  logic        w_last_blk;

  // Message length in words is recoverable from the bit length (always a multiple of 32).
  assign w_num_words = i_msg_bits[20:5];
  assign w_last_blk  = (i_blk == i_nb - 12'd1);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_value  = '0;
    o_is_mem = 1'b0;
    if (i_g < w_num_words) begin
      o_is_mem = 1'b1;
      o_value  = fmt_mem_word(i_mem_word);
    end else if (i_g == w_num_words) begin
      o_value = PAD_WORD;
    end else if (w_last_blk && i_slot == 4'd14) begin
      o_value = i_msg_bits[63:32];
    end else if (w_last_blk && i_slot == 4'd15) begin
      o_value = i_msg_bits[31:0];
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Fetches a message from word memory, pads it for SHA-256 and presents 512-bit blocks.
// Optional build macro SHA256_PAD_BSWAP_EN byte-reverses message words before buffering.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20,
  parameter int MEM_LAT      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         busy,
  output logic         done,
  output logic         mem_re,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  if (MEM_LAT != 1 || NUM_OF_WORDS < 1 || NUM_OF_WORDS > 1000) begin : g_param_chk
    $error("sha256_msg_padder: MEM_LAT must be 1 and NUM_OF_WORDS within 1..1000");
  end

  localparam logic [11:0] NB       = 12'(num_blocks(NUM_OF_WORDS));
  localparam logic [11:0] LAST_BLK = NB - 12'd1;
  localparam logic [63:0] MSG_BITS = 64'(NUM_OF_WORDS) * 64'd32;

  pad_state_e  r_state, w_next;
  logic [15:0] r_base;
  logic [11:0] r_blk;
  logic [3:0]  r_slot;
  logic        r_rd_pend;
  logic [3:0]  r_rd_slot;
  logic        r_done;
  logic [31:0] r_buf [WORDS_PER_BLOCK];

  logic [15:0] w_g;
  logic [31:0] w_slot_val;
  logic        w_slot_is_mem;
  logic        w_last_blk;

  assign w_g        = {r_blk, r_slot};
  assign w_last_blk = (r_blk == LAST_BLK);

  sha256_pad_sel u_pad_sel (
    .i_g        (w_g),
    .i_blk      (r_blk),
    .i_slot     (r_slot),
    .i_nb       (NB),
    .i_msg_bits (MSG_BITS),
    .i_mem_word (mem_read_data),
    .o_value    (w_slot_val),
    .o_is_mem   (w_slot_is_mem)
  );

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != ST_IDLE);
    done      = r_done;
    mem_re    = 1'b0;
    mem_addr  = '0;
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    blk_data  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_re = w_slot_is_mem;
        if (w_slot_is_mem) mem_addr = r_base + w_g;
        if (r_slot == 4'd15) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        blk_valid = 1'b1;
        blk_first = (r_blk == 12'd0);
        blk_last  = w_last_blk;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) blk_data[511-32*i -: 32] = r_buf[i];
        if (blk_ready) w_next = w_last_blk ? ST_IDLE : ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_blk     <= '0;
      r_slot    <= '0;
      r_rd_pend <= 1'b0;
      r_rd_slot <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= 1'b0;
      r_rd_pend <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base <= message_addr;
            r_blk  <= '0;
            r_slot <= '0;
          end
        end
        ST_FETCH: begin
          r_slot <= r_slot + 4'd1;
          if (w_slot_is_mem) begin
            r_rd_pend <= 1'b1;
            r_rd_slot <= r_slot;
          end
        end
        ST_PRESENT: begin
          if (blk_ready) begin
            if (w_last_blk) r_done <= 1'b1;
            else            r_blk  <= r_blk + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the block buffer has no reset; blk_data is forced to zero outside PRESENT instead.
  // Memory data lands one cycle after its read, in the slot recorded at issue time.
  always_ff @(posedge clk) begin
    if (r_state == ST_FETCH && !w_slot_is_mem) r_buf[r_slot] <= w_slot_val;
    if (r_rd_pend) r_buf[r_rd_slot] <= fmt_mem_word(mem_read_data);
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench: three padder instances (20, 13, 14 words) against a 1-cycle memory model.
module tb_sha256_msg_padder;

  localparam int NW [3] = '{20, 13, 14};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [3];
  logic         start     [3];
  logic [15:0]  maddr_in  [3];
  logic         busy      [3];
  logic         done      [3];
  logic         mem_re    [3];
  logic [15:0]  mem_addr  [3];
  logic [31:0]  rd        [3];
  logic         blk_valid [3];
  logic         blk_ready [3];
  logic [511:0] blk_data  [3];
  logic         blk_first [3];
  logic         blk_last  [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    sha256_msg_padder #(.NUM_OF_WORDS(NW[k]), .MEM_LAT(1)) u_dut (
      .clk           (clk),
      .reset         (rst[k]),
      .start         (start[k]),
      .message_addr  (maddr_in[k]),
      .busy          (busy[k]),
      .done          (done[k]),
      .mem_re        (mem_re[k]),
      .mem_addr      (mem_addr[k]),
      .mem_read_data (rd[k]),
      .blk_valid     (blk_valid[k]),
      .blk_ready     (blk_ready[k]),
      .blk_data      (blk_data[k]),
      .blk_first     (blk_first[k]),
      .blk_last      (blk_last[k])
    );
  end

  int           n_checks = 0;
  int           n_errors = 0;
  logic [15:0]  cur_base [3];
  int           rd_cnt   [3];
  int           addr_err [3];
  logic [511:0] got_blk  [3][2];

  // Message word i (at cur_base + i) holds i+1.
  function automatic logic [31:0] mem_val(input int k, input logic [15:0] a);
    logic [15:0] idx;
    idx = a - cur_base[k];
`ifdef SHA256_PAD_BSWAP_EN
    if (idx == 16'd0) return 32'h1122_3344;
`endif
    return {16'h0, idx} + 32'd1;
  endfunction

  function automatic logic [31:0] tb_fmt(input logic [31:0] w);
`ifdef SHA256_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] exp_block(input int k, input int n, input int b);
    logic [511:0] r;
    logic [63:0]  len;
    logic [31:0]  w;
    int           nb, g;
    nb  = (n + 2) / 16 + 1;
    len = 64'(n) * 64'd32;
    r   = '0;
    for (int s = 0; s < 16; s++) begin
      g = b * 16 + s;
      if (g < n)                      w = tb_fmt(mem_val(k, cur_base[k] + 16'(g)));
      else if (g == n)                w = 32'h8000_0000;
      else if (b == nb-1 && s == 14)  w = len[63:32];
      else if (b == nb-1 && s == 15)  w = len[31:0];
      else                            w = 32'h0;
      r[511-32*s -: 32] = w;
    end
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] blk, input int i);
    return blk[511-32*i -: 32];
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 3; k++) rd[k] <= mem_re[k] ? mem_val(k, mem_addr[k]) : 32'hDEAD_BEEF;

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (mem_re[k]) begin
        if (16'(mem_addr[k] - cur_base[k]) >= 16'(NW[k])) addr_err[k]++;
        rd_cnt[k]++;
      end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_ctrl"}, {busy[k], done[k], mem_re[k], blk_valid[k], blk_first[k], blk_last[k]}, '0);
    check({tag, "_addr"}, mem_addr[k], '0);
    check({tag, "_data"}, blk_data[k], '0);
  endtask

  task automatic run_msg(input int k, input logic [15:0] base, input bit hold);
    int n, nb, lat, rd0, ae0;
    logic [511:0] saved;
    n   = NW[k];
    nb  = (n + 2) / 16 + 1;
    cur_base[k] = base;
    rd0 = rd_cnt[k];
    ae0 = addr_err[k];
    @(posedge clk); #1;
    maddr_in[k] = base;
    start[k]    = 1'b1;
    @(posedge clk); #1;
    start[k]    = 1'b0;
    maddr_in[k] = 16'h5555;
    for (int b = 0; b < nb; b++) begin
      lat = 0;
      while (1) begin
        @(negedge clk);
        lat++;
        if (blk_valid[k] || lat >= 40) break;
      end
      check($sformatf("i%0d_b%0d_latency", k, b), lat, 18);
      if (!blk_valid[k]) return;
      check($sformatf("i%0d_b%0d_busy", k, b), busy[k], 1'b1);
      check($sformatf("i%0d_b%0d_data", k, b), blk_data[k], exp_block(k, n, b));
      check($sformatf("i%0d_b%0d_first", k, b), blk_first[k], b == 0);
      check($sformatf("i%0d_b%0d_last", k, b), blk_last[k], b == nb - 1);
      got_blk[k][b] = blk_data[k];
      if (hold && b == 0) begin
        saved = blk_data[k];
        for (int c = 0; c < 10; c++) begin
          @(posedge clk); #1;
          start[k]    = (c == 3);
          maddr_in[k] = 16'h1234;
          @(negedge clk);
          check($sformatf("hold%0d_valid_data_re", c), {blk_valid[k], mem_re[k], blk_data[k][509:0]},
                {1'b1, 1'b0, saved[509:0]});
          check($sformatf("hold%0d_top_bits", c), blk_data[k][511:510], saved[511:510]);
        end
      end
      blk_ready[k] = 1'b1;
      @(posedge clk); #1;
      blk_ready[k] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("i%0d_done_pulse", k), {done[k], busy[k], blk_valid[k]}, 3'b100);
    @(negedge clk);
    check($sformatf("i%0d_done_clear", k), done[k], 1'b0);
    check($sformatf("i%0d_read_count", k), rd_cnt[k] - rd0, n);
    check($sformatf("i%0d_addr_range", k), addr_err[k] - ae0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; maddr_in[k] = '0; blk_ready[k] = 1'b0;
      cur_base[k] = '0; rd_cnt[k] = 0; addr_err[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle(k, $sformatf("reset_i%0d", k));

    // 20 words starting near the top of the address space, so mem_addr wraps.
    run_msg(0, 16'hFFF8, 1'b0);
`ifdef SHA256_PAD_BSWAP_EN
    check("n20_b0_w0_swapped", word_of(got_blk[0][0], 0), 32'h4433_2211);
`else
    check("n20_b0_w0", word_of(got_blk[0][0], 0), 32'h1);
    check("n20_b0_w15", word_of(got_blk[0][0], 15), 32'h10);
    check("n20_b1_w3", word_of(got_blk[0][1], 3), 32'h14);
`endif
    check("n20_b1_w4_pad", word_of(got_blk[0][1], 4), 32'h8000_0000);
    check("n20_b1_w13", word_of(got_blk[0][1], 13), 32'h0);
    check("n20_b1_w14", word_of(got_blk[0][1], 14), 32'h0);
    check("n20_b1_w15_len", word_of(got_blk[0][1], 15), 32'h280);

    run_msg(1, 16'h0040, 1'b0);
    check("n13_w13_pad", word_of(got_blk[1][0], 13), 32'h8000_0000);
    check("n13_w14", word_of(got_blk[1][0], 14), 32'h0);
    check("n13_w15_len", word_of(got_blk[1][0], 15), 32'h1A0);

    run_msg(2, 16'h0200, 1'b0);
    check("n14_b0_w14_pad", word_of(got_blk[2][0], 14), 32'h8000_0000);
    check("n14_b0_w15", word_of(got_blk[2][0], 15), 32'h0);
    check("n14_b1_all", got_blk[2][1], {480'h0, 32'h1C0});

    // Back-pressure for 10 cycles with a stray start in the middle.
    run_msg(0, 16'h0100, 1'b1);

    // Reset during the 5th FETCH cycle.
    cur_base[0] = 16'h0700;
    @(posedge clk); #1;
    maddr_in[0] = 16'h0700;
    start[0]    = 1'b1;
    @(posedge clk); #1;
    start[0]    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_fetch_re", {busy[0], mem_re[0]}, 2'b11);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "mid_fetch_reset");

    run_msg(0, 16'h0300, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
